// File: rtl/regfile_n.sv
// Parametrised register file: NREGS x WIDTH, two combinational read ports, one write port,
// auto-incrementing PC (top register) and push/pop SP (next register down) with sticky wrap fault.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_n #(
    parameter int              WIDTH   = 16,
    parameter int              NREGS   = 8,
    parameter int              SEL_W   = $clog2(NREGS),
    parameter logic [WIDTH-1:0] SP_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] src_sel,
    input  logic [SEL_W-1:0] dst_sel,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in,
    input  logic             out_en,
    input  logic             pc_inc,
    input  logic             sp_inc,
    input  logic             sp_dec,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] src,
    output logic [WIDTH-1:0] dst,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] sp,
    output logic             sp_err
);

    localparam logic [SEL_W-1:0] PC_IDX = SEL_W'(NREGS - 1);
    localparam logic [SEL_W-1:0] SP_IDX = SEL_W'(NREGS - 2);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [WIDTH-1:0] regs [NREGS];

    logic write_pc;
    logic write_sp;
    logic sp_up;
    logic sp_down;
    logic sp_wrap;

    assign pc = regs[PC_IDX];
    assign sp = regs[SP_IDX];

    assign write_pc = in_en && (dst_sel == PC_IDX);
    assign write_sp = in_en && (dst_sel == SP_IDX);

    // A simultaneous inc+dec cancels out, and a bus write to SP overrides any step.
    assign sp_up   = sp_inc && !sp_dec && !write_sp;
    assign sp_down = sp_dec && !sp_inc && !write_sp;
    assign sp_wrap = (sp_up && (sp == '1)) || (sp_down && (sp == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == NREGS - 2) ? SP_INIT : '0;
            end
            sp_err <= 1'b0;
        end else begin
            if (pc_inc && !write_pc) begin
                regs[PC_IDX] <= pc + ONE;
            end
            if (sp_up) begin
                regs[SP_IDX] <= sp + ONE;
            end else if (sp_down) begin
                regs[SP_IDX] <= sp - ONE;
            end
            if (sp_wrap) begin
                sp_err <= 1'b1;
            end
            if (in_en) begin
                regs[dst_sel] <= in;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic gen_write;
    logic fwd_src;
    logic fwd_dst;

    // Only bus writes to general registers are forwarded; PC/SP arithmetic never is.
    assign gen_write = in_en && (dst_sel < SP_IDX);
    assign fwd_src   = gen_write && (src_sel == dst_sel);
    assign fwd_dst   = gen_write;

    assign src = fwd_src ? in : regs[src_sel];
    assign dst = fwd_dst ? in : regs[dst_sel];
`else
    assign src = regs[src_sel];
    assign dst = regs[dst_sel];
`endif

    assign out = out_en ? src : '0;

endmodule

// File: tb/tb_regfile_n.sv
// Self-checking bench for regfile_n: directed test-plan steps followed by random traffic,
// all outputs compared every cycle against an array-based reference model.
module tb_regfile_n;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int SEL_W = 3;
    localparam int SP_I  = NREGS - 2;
    localparam int PC_I  = NREGS - 1;

    logic             clk;
    logic             rst;
    logic [SEL_W-1:0] src_sel;
    logic [SEL_W-1:0] dst_sel;
    logic             in_en;
    logic [WIDTH-1:0] in;
    logic             out_en;
    logic             pc_inc;
    logic             sp_inc;
    logic             sp_dec;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] dst;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] sp;
    logic             sp_err;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] model [NREGS];
    logic             model_err;
    logic             model_valid = 1'b0;

    regfile_n #(
        .WIDTH  (WIDTH),
        .NREGS  (NREGS),
        .SP_INIT(16'h0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .src_sel(src_sel),
        .dst_sel(dst_sel),
        .in_en  (in_en),
        .in     (in),
        .out_en (out_en),
        .pc_inc (pc_inc),
        .sp_inc (sp_inc),
        .sp_dec (sp_dec),
        .out    (out),
        .src    (src),
        .dst    (dst),
        .pc     (pc),
        .sp     (sp),
        .sp_err (sp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected read-port values from the model, including write-through when forwarding is built in.
    task automatic check_output();
        logic [WIDTH-1:0] exp_src;
        logic [WIDTH-1:0] exp_dst;
        exp_src = model[src_sel];
        exp_dst = model[dst_sel];
`ifdef REGFILE_BYPASS_EN
        if (in_en && int'(dst_sel) < SP_I) begin
            exp_dst = in;
            if (src_sel == dst_sel) exp_src = in;
        end
`endif
        check_val("src", src, exp_src);
        check_val("dst", dst, exp_dst);
        check_val("out", out, out_en ? exp_src : 16'h0000);
        check_val("pc", pc, model[PC_I]);
        check_val("sp", sp, model[SP_I]);
        check_val("sp_err", {15'b0, sp_err}, {15'b0, model_err});
    endtask

    // Reference behaviour for one clock edge, from the register-file rules.
    task automatic model_edge();
        logic [WIDTH-1:0] nxt [NREGS];
        int net;
        int s;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
            model[SP_I] = 16'h0000;
            model_err   = 1'b0;
            model_valid = 1'b1;
            return;
        end
        for (int i = 0; i < NREGS; i++) nxt[i] = model[i];
        if (pc_inc) nxt[PC_I] = model[PC_I] + 16'd1;
        net = int'(sp_inc) - int'(sp_dec);
        if (net != 0 && !(in_en && int'(dst_sel) == SP_I)) begin
            s = int'(model[SP_I]) + net;
            if (s < 0 || s > 65535) model_err = 1'b1;
            nxt[SP_I] = 16'(s);
        end
        if (in_en) nxt[dst_sel] = in;
        for (int i = 0; i < NREGS; i++) model[i] = nxt[i];
    endtask

    task automatic apply_stimulus(input logic r, input logic [SEL_W-1:0] s_sel,
                                  input logic [SEL_W-1:0] d_sel, input logic w_en,
                                  input logic [WIDTH-1:0] w_data, input logic o_en,
                                  input logic p_inc, input logic s_inc, input logic s_dec);
        @(negedge clk);
        rst     = r;
        src_sel = s_sel;
        dst_sel = d_sel;
        in_en   = w_en;
        in      = w_data;
        out_en  = o_en;
        pc_inc  = p_inc;
        sp_inc  = s_inc;
        sp_dec  = s_dec;
        #1;
        if (model_valid) check_output();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b0; src_sel = '0; dst_sel = '0; in_en = 1'b0; in = '0;
        out_en = 1'b0; pc_inc = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0;

        // Reset then read
        apply_stimulus(1, 0, 1, 0, 16'h0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 16'h0, 1, 0, 0, 0);
        check_val("rst_out", out, 16'h0);
        check_val("rst_src", src, 16'h0);
        check_val("rst_dst", dst, 16'h0);
        check_val("rst_pc", pc, 16'h0);
        check_val("rst_sp", sp, 16'h0);
        check_val("rst_err", {15'b0, sp_err}, 16'h0);

        // Write/read
        apply_stimulus(0, 0, 2, 1, 16'd10, 0, 0, 0, 0);
        apply_stimulus(0, 0, 3, 1, 16'd20, 0, 0, 0, 0);
        apply_stimulus(0, 2, 3, 0, 16'h0, 1, 0, 0, 0);
        check_val("wr_src", src, 16'd10);
        check_val("wr_dst", dst, 16'd20);
        check_val("wr_out", out, 16'd10);
        apply_stimulus(0, 2, 3, 0, 16'h0, 0, 0, 0, 0);
        check_val("wr_out_off", out, 16'h0);

        // PC increment, wrap and write priority
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 16'h0, 0, 1, 0, 0);
        check_val("pc_three", pc, 16'd3);
        apply_stimulus(0, 0, 7, 1, 16'hFFFF, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 1, 0, 0);
        check_val("pc_wrap", pc, 16'h0000);
        apply_stimulus(0, 0, 7, 1, 16'h0100, 0, 1, 0, 0);
        check_val("pc_wr_prio", pc, 16'h0100);

        // SP push/pop, sticky fault, cancelled step, reset clear
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 0, 0, 1);
        check_val("sp_under", sp, 16'hFFFF);
        check_val("sp_err_set", {15'b0, sp_err}, 16'h1);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 0, 1, 0);
        check_val("sp_over", sp, 16'h0000);
        check_val("sp_err_sticky", {15'b0, sp_err}, 16'h1);
        apply_stimulus(0, 0, 0, 0, 16'h0, 0, 0, 1, 1);
        check_val("sp_cancel", sp, 16'h0000);
        apply_stimulus(1, 0, 0, 0, 16'h0, 0, 0, 0, 0);
        check_val("sp_err_clr", {15'b0, sp_err}, 16'h0);

        // Reset priority over a write
        apply_stimulus(1, 0, 4, 1, 16'h0055, 0, 0, 0, 0);
        apply_stimulus(0, 4, 0, 0, 16'h0, 1, 0, 0, 0);
        check_val("rst_prio", src, 16'h0000);

        // Same-cycle read-after-write, then registered value
        apply_stimulus(0, 0, 5, 1, 16'h0AAA, 0, 0, 0, 0);
        apply_stimulus(0, 5, 5, 1, 16'h1234, 1, 0, 0, 0);
        apply_stimulus(0, 5, 0, 0, 16'h0, 1, 0, 0, 0);
        check_val("raw_next", src, 16'h1234);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(($urandom_range(31) == 0),
                           SEL_W'($urandom_range(NREGS - 1)),
                           SEL_W'($urandom_range(NREGS - 1)),
                           ($urandom_range(3) == 0),
                           WIDTH'(($urandom_range(3) == 0) ? 16'hFFFF : $urandom),
                           1'($urandom),
                           1'($urandom),
                           ($urandom_range(2) == 0),
                           ($urandom_range(2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
